wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//   Two-port register-file writeback arbiter. Requester 0 is the ALU writeback
//   path, requester 1 is the load writeback path. At most one request is
//   accepted per cycle (ready is combinational on valid), and the accepted
//   address/data are registered and presented to the register file for one
//   cycle. Back-to-back writes sustain one write per cycle.
//
//   Writes to register 0 are accepted but never reach the register file.
//
//   Configuration macro:
//     WB_ROUND_ROBIN_EN  defined   : ties alternate (winner != last_grant)
//                        undefined : ties always go to requester 0
//
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     reqN_valid/addr/data       requester N pending write (N = 0, 1)
//     reqN_ready                 requester N accepted this cycle
//     wb_en/wb_addr/wb_data      register-file write port (1 cycle after accept)
//     wb_sel                     write-address mux select (0 = req0, 1 = req1)
//     busy                       some valid request is waiting this cycle
// -----------------------------------------------------------------------------
module wb_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        wb_sel,
  output logic        busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_sel_q, wb_sel_d;
  logic        last_grant_q, last_grant_d;

  logic        tie_to_0;
  logic        gnt0, gnt1, accept;
  logic [4:0]  acc_addr;
  logic [31:0] acc_data;
  logic        wr_fire;

  // Tie resolution. last_grant is tracked in both builds so it is observable
  // the same way; the fixed-priority build simply never lets it matter.
`ifdef WB_ROUND_ROBIN_EN
  assign tie_to_0 = last_grant_q;          // last winner was 1 -> give it to 0
`else
  assign tie_to_0 = last_grant_q | 1'b1;   // requester 0 always wins ties
`endif

  // Grants are gated by rst_n so nothing is acknowledged while held in reset,
  // even though the requesters may keep their valids high.
  always_comb begin
    gnt0 = rst_n & req0_valid & (~req1_valid | tie_to_0);
    gnt1 = rst_n & req1_valid & ~gnt0;
  end

  assign accept   = gnt0 | gnt1;
  assign acc_addr = gnt1 ? req1_addr : req0_addr;
  assign acc_data = gnt1 ? req1_data : req0_data;

  // Register 0 is hard-wired: accept the request but suppress the write.
  assign wr_fire  = accept & (acc_addr != 5'd0);

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign busy       = (req0_valid & ~gnt0) | (req1_valid & ~gnt1);

  always_comb begin
    state_d      = wr_fire ? WRITE : IDLE;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    wb_sel_d     = wb_sel_q;
    last_grant_d = last_grant_q;
    // Write-port registers only move on a real write so they hold their last
    // values through IDLE cycles (including suppressed register-0 writes).
    if (wr_fire) begin
      wb_addr_d = acc_addr;
      wb_data_d = acc_data;
      wb_sel_d  = gnt1;
    end
    if (accept) last_grant_d = gnt1;
  end

  // last_grant resets to 1 so requester 0 wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wb_addr_q    <= 5'd0;
      wb_data_q    <= 32'd0;
      wb_sel_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      wb_sel_q     <= wb_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign wb_en   = (state_q == WRITE);
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign wb_sel  = wb_sel_q;

`ifndef SYNTHESIS
  // Structural sanity: one grant at most, and only to a requester asking.
  always @(posedge clk) begin
    if (rst_n) begin
      a_one_hot:    assert (!(req0_ready && req1_ready));
      a_rdy0_valid: assert (!req0_ready || req0_valid);
      a_rdy1_valid: assert (!req1_ready || req1_valid);
    end
  end
`endif

endmodule
